// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: command modes, FSM states and
// default field widths used by led_seq_ctrl and its tick generator.
package led_seq_pkg;

  localparam int DUR_W_DEF = 10;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_BL_ON  = 3'd2,
    ST_BL_OFF = 3'd3,
    ST_BU_ON  = 3'd4,
    ST_BU_OFF = 3'd5
  } state_t;

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks; a synchronous clear
// restarts it so the first tick lands exactly DIV cycles after the clear edge.
module tick_gen #(
  parameter int DIV = 16000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clr || (cnt_q == PW'(DIV - 1))) begin
      cnt_d = '0;
    end
  end

  // Tick is suppressed on the clear cycle so a restart never emits a short tick.
  assign tick = !clr && (cnt_q == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Command-driven LED sequencer for pin13: off, steady on, continuous blink
// and counted bursts, with on/off phases measured in prescaled ticks.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ  = 16000000,
  parameter int TICK_HZ = 1000,
  parameter int DUR_W   = DUR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             pin3_clk_16mhz,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [DUR_W-1:0] cmd_on,
  input  logic [DUR_W-1:0] cmd_off,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             busy,
  output logic             done,
  output logic             pin13
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("led_seq_ctrl: CLK_HZ must be a multiple of TICK_HZ with a ratio of at least 2");
  end

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on registered state.
  logic accept;
  logic tick;

  state_t           state_q, state_d;
  logic             pin13_q, pin13_d;
  logic             done_q, done_d;
  logic [DUR_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DUR_W-1:0] on_len_q, on_len_d;
  logic [DUR_W-1:0] off_len_q, off_len_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DUR_W-1:0] phase_len;
  logic             in_phase;

  assign accept = cmd_valid && cmd_ready;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (pin3_clk_16mhz),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge pin3_clk_16mhz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pin13_q    <= 1'b0;
      done_q     <= 1'b0;
      tick_cnt_q <= '0;
      on_len_q   <= '0;
      off_len_q  <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      pin13_q    <= pin13_d;
      done_q     <= done_d;
      tick_cnt_q <= tick_cnt_d;
      on_len_q   <= on_len_d;
      off_len_q  <= off_len_d;
      rem_q      <= rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pin13_d    = pin13_q;
    done_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    on_len_d   = on_len_q;
    off_len_d  = off_len_q;
    rem_d      = rem_q;
    in_phase   = (state_q == ST_BL_ON) || (state_q == ST_BL_OFF) ||
                 (state_q == ST_BU_ON) || (state_q == ST_BU_OFF);
    phase_len  = ((state_q == ST_BL_ON) || (state_q == ST_BU_ON)) ? on_len_q : off_len_q;

    if (accept) begin
      tick_cnt_d = '0;
      // A zero duration is stretched to one tick so every phase is visible.
      on_len_d   = (cmd_on  == '0) ? DUR_W'(1) : cmd_on;
      off_len_d  = (cmd_off == '0) ? DUR_W'(1) : cmd_off;
      rem_d      = cmd_count;
      case (cmd_mode)
        MODE_ON: begin
          state_d = ST_HOLD;
          pin13_d = 1'b1;
        end
        MODE_BLINK: begin
          state_d = ST_BL_ON;
          pin13_d = 1'b1;
        end
        MODE_BURST: begin
          if (cmd_count != '0) begin
            state_d = ST_BU_ON;
            pin13_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            pin13_d = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pin13_d = 1'b0;
        end
      endcase
    end else if (tick && in_phase) begin
      if ((tick_cnt_q + DUR_W'(1)) == phase_len) begin
        tick_cnt_d = '0;
        case (state_q)
          ST_BL_ON: begin
            state_d = ST_BL_OFF;
            pin13_d = 1'b0;
          end
          ST_BL_OFF: begin
            state_d = ST_BL_ON;
            pin13_d = 1'b1;
          end
          ST_BU_ON: begin
            state_d = ST_BU_OFF;
            pin13_d = 1'b0;
          end
          default: begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              pin13_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_BU_ON;
              pin13_d = 1'b1;
            end
          end
        endcase
      end else begin
        tick_cnt_d = tick_cnt_q + DUR_W'(1);
      end
    end
  end

  always_comb begin
    cmd_ready = 1'b1;
    busy      = 1'b0;
    if ((state_q == ST_BU_ON) || (state_q == ST_BU_OFF)) begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
    end
  end

  assign pin13 = pin13_q;
  assign done  = done_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed and randomized bench for led_seq_ctrl; the reference model derives
// every output from the time elapsed since the last accepted command.
module tb_led_seq_ctrl;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [9:0] cmd_on = '0;
  logic [9:0] cmd_off = '0;
  logic [3:0] cmd_count = '0;
  logic       busy;
  logic       done;
  logic       pin13;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: last accepted command and the edge that accepted it.
  int  m_mode = 0;
  int  m_on = 1;
  int  m_off = 1;
  int  m_cnt = 0;
  int  m_t0 = 0;
  bit  acc = 1'b0;

  led_seq_ctrl #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DUR_W   (10),
    .CNT_W   (4)
  ) dut (
    .pin3_clk_16mhz (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mode       (cmd_mode),
    .cmd_on         (cmd_on),
    .cmd_off        (cmd_off),
    .cmd_count      (cmd_count),
    .busy           (busy),
    .done           (done),
    .pin13          (pin13)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d got=%0b exp=%0b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_outs(output logic p, output logic b, output logic d, output logic r);
    int e, ond, per;
    e   = cyc - m_t0;
    ond = m_on * DIV;
    per = (m_on + m_off) * DIV;
    p = 1'b0; b = 1'b0; d = 1'b0; r = 1'b1;
    case (m_mode)
      1: p = 1'b1;
      2: p = ((e % per) < ond);
      3: begin
        if (m_cnt == 0) begin
          d = (e == 0);
        end else if (e < m_cnt * per) begin
          p = ((e % per) < ond);
          b = 1'b1;
          r = 1'b0;
        end else begin
          d = (e == m_cnt * per);
        end
      end
      default: ;
    endcase
  endtask

  task automatic step();
    logic p, b, d, r;
    model_outs(p, b, d, r);
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_mode = 0;
      m_t0   = cyc;
    end else if (cmd_valid && r) begin
      m_mode = int'(cmd_mode);
      m_on   = (cmd_on == 0) ? 1 : int'(cmd_on);
      m_off  = (cmd_off == 0) ? 1 : int'(cmd_off);
      m_cnt  = int'(cmd_count);
      m_t0   = cyc;
      acc    = 1'b1;
    end
    #1;
    model_outs(p, b, d, r);
    chk("pin13", pin13, p);
    chk("busy", busy, b);
    chk("done", done, d);
    chk("cmd_ready", cmd_ready, r);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int mode, input int on, input int off, input int cnt);
    cmd_mode  = 2'(mode);
    cmd_on    = 10'(on);
    cmd_off   = 10'(off);
    cmd_count = 4'(cnt);
    cmd_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 2000 && !acc; i++) step();
    cmd_valid = 1'b0;
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL accept_timeout got=0 exp=1");
    end
  endtask

  task automatic async_reset(input int hold);
    #2;
    rst = 1'b1;
    m_mode = 0;
    m_t0 = cyc;
    #1;
    chk("rst_pin13", pin13, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    steps(hold);
    rst = 1'b0;
  endtask

  initial begin
    int b0;
    #1 rst = 1'b1;
    #1;
    chk("init_pin13", pin13, 1'b0);
    chk("init_ready", cmd_ready, 1'b1);
    chk("init_busy", busy, 1'b0);
    chk("init_done", done, 1'b0);
    steps(2);
    rst = 1'b0;
    steps(3);

    // ON then OFF five cycles apart
    send(1, 0, 0, 0);
    steps(4);
    send(0, 0, 0, 0);
    steps(5);

    // Reset while held on
    send(1, 0, 0, 0);
    steps(3);
    async_reset(2);
    steps(3);

    // Continuous blink, then preempt mid-phase with OFF
    send(2, 3, 2, 0);
    steps(167);
    send(0, 0, 0, 0);
    steps(5);

    // Burst of three
    send(3, 1, 1, 3);
    steps(70);

    // Empty burst
    send(3, 4, 4, 0);
    steps(6);

    // Zero-length phases with an ON command waiting through the burst
    send(3, 0, 0, 2);
    b0 = m_t0;
    cmd_mode = 2'd1;
    cmd_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step();
    cmd_valid = 1'b0;
    chk_int("on_after_done", m_t0 - b0, 41);
    steps(6);

    // Reset in the middle of a burst
    send(3, 2, 2, 3);
    steps(25);
    async_reset(1);
    steps(12);

    // Randomized commands, some arriving mid-phase or mid-burst
    for (int k = 0; k < 12; k++) begin
      send($urandom_range(3, 0), $urandom_range(4, 0), $urandom_range(4, 0),
           $urandom_range(3, 0));
      steps($urandom_range(120, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
